// File: rtl/ysyx_22040632_pkg.sv
// Shared widths, writeback request struct and grant encoding for the writeback arbiter slice.
package ysyx_22040632_pkg;
  localparam int XLEN   = 64;
  localparam int REG_AW = 5;
  localparam int NREG   = 32;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

  typedef enum logic {
    GRANT_EXU = 1'b0,
    GRANT_LSU = 1'b1
  } grant_e;
endpackage

// File: rtl/ysyx_22040632_rf_wb_arbiter_if.sv
// Writeback, register-file, issue-reservation and hazard-query signals of the arbiter.
interface ysyx_22040632_rf_wb_arbiter_if #(
  parameter int XLEN = 64
);
  import ysyx_22040632_pkg::REG_AW;

  logic              exu_wb_valid;
  logic              exu_wb_ready;
  logic [REG_AW-1:0] exu_wb_rd;
  logic [XLEN-1:0]   exu_wb_data;
  logic              lsu_wb_valid;
  logic              lsu_wb_ready;
  logic [REG_AW-1:0] lsu_wb_rd;
  logic [XLEN-1:0]   lsu_wb_data;
  logic              rf_wen;
  logic [REG_AW-1:0] rf_waddr;
  logic [XLEN-1:0]   rf_wdata;
  logic              iss_valid;
  logic              iss_ready;
  logic [REG_AW-1:0] iss_rd;
  logic [REG_AW-1:0] rs1_addr;
  logic [REG_AW-1:0] rs2_addr;
  logic              rs1_busy;
  logic              rs2_busy;

  modport master (
    output exu_wb_valid, exu_wb_rd, exu_wb_data,
    output lsu_wb_valid, lsu_wb_rd, lsu_wb_data,
    output iss_valid, iss_rd, rs1_addr, rs2_addr,
    input  exu_wb_ready, lsu_wb_ready, iss_ready, rs1_busy, rs2_busy,
    input  rf_wen, rf_waddr, rf_wdata
  );

  modport slave (
    input  exu_wb_valid, exu_wb_rd, exu_wb_data,
    input  lsu_wb_valid, lsu_wb_rd, lsu_wb_data,
    input  iss_valid, iss_rd, rs1_addr, rs2_addr,
    output exu_wb_ready, lsu_wb_ready, iss_ready, rs1_busy, rs2_busy,
    output rf_wen, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/ysyx_22040632_scoreboard.sv
// Destination-register busy vector: reserved at issue, released by the register-file write.
// Define YSYX_22040632_WB_BYPASS_EN to hide busy for a source being written this cycle.
module ysyx_22040632_scoreboard #(
  parameter int NREG   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iss_valid,
  input  logic [REG_AW-1:0] iss_rd,
  output logic              iss_ready,
  input  logic              rf_wen,
  input  logic [REG_AW-1:0] rf_waddr,
  input  logic [REG_AW-1:0] rs1_addr,
  input  logic [REG_AW-1:0] rs2_addr,
  output logic              rs1_busy,
  output logic              rs2_busy
);
  logic [NREG-1:0] busy_reg;
  logic [NREG-1:0] busy_next;
  logic            set_en;
  logic            rs1_hit;
  logic            rs2_hit;

  assign iss_ready = rst_n && !busy_reg[iss_rd];
  assign set_en    = iss_valid && iss_ready && (iss_rd != '0);

  // x0 is never reserved; a new reservation outranks a same-cycle release.
  assign busy_next[0] = 1'b0;
  for (genvar gi = 1; gi < NREG; gi++) begin : g_busy
    assign busy_next[gi] = (set_en && (iss_rd == REG_AW'(gi))) ||
                           (busy_reg[gi] && !(rf_wen && (rf_waddr == REG_AW'(gi))));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

`ifdef YSYX_22040632_WB_BYPASS_EN
  assign rs1_hit = rf_wen && (rf_waddr == rs1_addr);
  assign rs2_hit = rf_wen && (rf_waddr == rs2_addr);
`else
  assign rs1_hit = 1'b0;
  assign rs2_hit = 1'b0;
`endif

  assign rs1_busy = busy_reg[rs1_addr] && !rs1_hit;
  assign rs2_busy = busy_reg[rs2_addr] && !rs2_hit;
endmodule

// File: rtl/ysyx_22040632_rf_wb_arbiter.sv
// Round-robin EXU/LSU writeback arbiter with a registered register-file write port.
// YSYX_22040632_WB_BYPASS_EN (see scoreboard) masks hazards on the register being written.
module ysyx_22040632_rf_wb_arbiter #(
  parameter int XLEN = ysyx_22040632_pkg::XLEN,
  parameter int NREG = ysyx_22040632_pkg::NREG
) (
  input logic                         clk,
  input logic                         rst_n,
  ysyx_22040632_rf_wb_arbiter_if.slave bus
);
  import ysyx_22040632_pkg::*;

  grant_e            last_grant_reg;
  logic              grant_exu;
  logic              grant_lsu;
  logic              exu_fire;
  logic              lsu_fire;
  logic              wb_fire;
  wb_req_t           req_sel;
  logic              rf_wen_reg;
  logic [REG_AW-1:0] rf_waddr_reg;
  logic [XLEN-1:0]   rf_wdata_reg;

  // EXU takes a tie only when LSU had the previous grant.
  assign grant_exu = bus.exu_wb_valid && (!bus.lsu_wb_valid || (last_grant_reg == GRANT_LSU));
  assign grant_lsu = bus.lsu_wb_valid && !grant_exu;

  assign bus.exu_wb_ready = rst_n && grant_exu;
  assign bus.lsu_wb_ready = rst_n && grant_lsu;

  assign exu_fire = bus.exu_wb_valid && bus.exu_wb_ready;
  assign lsu_fire = bus.lsu_wb_valid && bus.lsu_wb_ready;
  assign wb_fire  = exu_fire || lsu_fire;

  always_comb begin
    req_sel = '0;
    if (exu_fire) begin
      req_sel.rd   = bus.exu_wb_rd;
      req_sel.data = bus.exu_wb_data;
    end else begin
      req_sel.rd   = bus.lsu_wb_rd;
      req_sel.data = bus.lsu_wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_wen_reg     <= 1'b0;
      rf_waddr_reg   <= '0;
      rf_wdata_reg   <= '0;
      last_grant_reg <= GRANT_LSU;
    end else begin
      // x0 writebacks are consumed but never reach the register file.
      rf_wen_reg <= wb_fire && (req_sel.rd != '0);
      if (wb_fire) begin
        rf_waddr_reg   <= req_sel.rd;
        rf_wdata_reg   <= req_sel.data;
        last_grant_reg <= exu_fire ? GRANT_EXU : GRANT_LSU;
      end
    end
  end

  assign bus.rf_wen   = rf_wen_reg;
  assign bus.rf_waddr = rf_waddr_reg;
  assign bus.rf_wdata = rf_wdata_reg;

  ysyx_22040632_scoreboard #(
    .NREG   (NREG),
    .REG_AW (REG_AW)
  ) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .iss_valid (bus.iss_valid),
    .iss_rd    (bus.iss_rd),
    .iss_ready (bus.iss_ready),
    .rf_wen    (rf_wen_reg),
    .rf_waddr  (rf_waddr_reg),
    .rs1_addr  (bus.rs1_addr),
    .rs2_addr  (bus.rs2_addr),
    .rs1_busy  (bus.rs1_busy),
    .rs2_busy  (bus.rs2_busy)
  );
endmodule

// File: tb/tb_ysyx_22040632_rf_wb_arbiter.sv
// Directed self-checking bench for the writeback arbiter and its busy scoreboard.
module tb_ysyx_22040632_rf_wb_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  ysyx_22040632_rf_wb_arbiter_if #(.XLEN(64)) bus ();

  ysyx_22040632_rf_wb_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.exu_wb_valid = 1'b0; bus.exu_wb_rd = '0; bus.exu_wb_data = '0;
    bus.lsu_wb_valid = 1'b0; bus.lsu_wb_rd = '0; bus.lsu_wb_data = '0;
    bus.iss_valid = 1'b0; bus.iss_rd = '0;
    bus.rs1_addr = '0; bus.rs2_addr = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    n_checks++; if (bus.rf_wen !== 1'b0) begin n_fail++; $display("FAIL reset_rf_wen act=%0h exp=0", bus.rf_wen); end
    n_checks++; if (bus.rf_waddr !== 5'd0) begin n_fail++; $display("FAIL reset_rf_waddr act=%0h exp=0", bus.rf_waddr); end
    n_checks++; if (bus.rf_wdata !== 64'd0) begin n_fail++; $display("FAIL reset_rf_wdata act=%0h exp=0", bus.rf_wdata); end
    bus.exu_wb_valid = 1'b1;
    bus.lsu_wb_valid = 1'b1;
    #1;
    n_checks++; if (bus.exu_wb_ready !== 1'b0) begin n_fail++; $display("FAIL reset_exu_ready act=%0h exp=0", bus.exu_wb_ready); end
    n_checks++; if (bus.lsu_wb_ready !== 1'b0) begin n_fail++; $display("FAIL reset_lsu_ready act=%0h exp=0", bus.lsu_wb_ready); end
    idle_inputs();
    rst_n = 1'b1;
    $display("reset: rf_wen=%0h waddr=%0h wdata=%0h", bus.rf_wen, bus.rf_waddr, bus.rf_wdata);
  endtask

  task automatic test_exu_single();
    bus.exu_wb_valid = 1'b1; bus.exu_wb_rd = 5'd5; bus.exu_wb_data = 64'h1234;
    #1;
    n_checks++; if (bus.exu_wb_ready !== 1'b1) begin n_fail++; $display("FAIL exu_single_ready act=%0h exp=1", bus.exu_wb_ready); end
    n_checks++; if (bus.lsu_wb_ready !== 1'b0) begin n_fail++; $display("FAIL exu_single_lsu_ready act=%0h exp=0", bus.lsu_wb_ready); end
    step();
    idle_inputs();
    n_checks++; if (bus.rf_wen !== 1'b1) begin n_fail++; $display("FAIL exu_single_wen act=%0h exp=1", bus.rf_wen); end
    n_checks++; if (bus.rf_waddr !== 5'd5) begin n_fail++; $display("FAIL exu_single_waddr act=%0h exp=5", bus.rf_waddr); end
    n_checks++; if (bus.rf_wdata !== 64'h1234) begin n_fail++; $display("FAIL exu_single_wdata act=%0h exp=1234", bus.rf_wdata); end
    $display("exu_single: rd=5 data=1234 -> wen=%0h waddr=%0h wdata=%0h", bus.rf_wen, bus.rf_waddr, bus.rf_wdata);
    step();
    n_checks++; if (bus.rf_wen !== 1'b0) begin n_fail++; $display("FAIL exu_single_pulse act=%0h exp=0", bus.rf_wen); end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  exp_rd;
    logic [63:0] exp_data;
    logic        exp_exu;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus.exu_wb_valid = 1'b1; bus.exu_wb_rd = 5'(1 + i); bus.exu_wb_data = 64'hE000 + 64'(i);
      bus.lsu_wb_valid = 1'b1; bus.lsu_wb_rd = 5'(10 + i); bus.lsu_wb_data = 64'hA000 + 64'(i);
      exp_exu  = (i % 2 == 0);
      exp_rd   = exp_exu ? 5'(1 + i) : 5'(10 + i);
      exp_data = exp_exu ? 64'hE000 + 64'(i) : 64'hA000 + 64'(i);
      #1;
      n_checks++; if (bus.exu_wb_ready !== exp_exu) begin n_fail++; $display("FAIL rr_exu_ready[%0d] act=%0h exp=%0h", i, bus.exu_wb_ready, exp_exu); end
      n_checks++; if (bus.lsu_wb_ready !== !exp_exu) begin n_fail++; $display("FAIL rr_lsu_ready[%0d] act=%0h exp=%0h", i, bus.lsu_wb_ready, !exp_exu); end
      step();
      n_checks++; if (bus.rf_wen !== 1'b1) begin n_fail++; $display("FAIL rr_wen[%0d] act=%0h exp=1", i, bus.rf_wen); end
      n_checks++; if (bus.rf_waddr !== exp_rd) begin n_fail++; $display("FAIL rr_waddr[%0d] act=%0h exp=%0h", i, bus.rf_waddr, exp_rd); end
      n_checks++; if (bus.rf_wdata !== exp_data) begin n_fail++; $display("FAIL rr_wdata[%0d] act=%0h exp=%0h", i, bus.rf_wdata, exp_data); end
      $display("back_to_back[%0d]: grant=%s waddr=%0h wdata=%0h", i, exp_exu ? "EXU" : "LSU", bus.rf_waddr, bus.rf_wdata);
    end
    idle_inputs();
    step();
    n_checks++; if (bus.rf_wen !== 1'b0) begin n_fail++; $display("FAIL rr_idle_wen act=%0h exp=0", bus.rf_wen); end
    // last grant was LSU; an idle cycle must not change it
    bus.exu_wb_valid = 1'b1; bus.lsu_wb_valid = 1'b1;
    #1;
    n_checks++; if (bus.exu_wb_ready !== 1'b1) begin n_fail++; $display("FAIL rr_after_idle_exu_ready act=%0h exp=1", bus.exu_wb_ready); end
    idle_inputs();
  endtask

  task automatic test_x0_write();
    bus.lsu_wb_valid = 1'b1; bus.lsu_wb_rd = 5'd0; bus.lsu_wb_data = 64'hFF;
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd3;
    #1;
    n_checks++; if (bus.lsu_wb_ready !== 1'b1) begin n_fail++; $display("FAIL x0_lsu_ready act=%0h exp=1", bus.lsu_wb_ready); end
    step();
    idle_inputs();
    bus.rs1_addr = 5'd3; bus.rs2_addr = 5'd0;
    #1;
    n_checks++; if (bus.rf_wen !== 1'b0) begin n_fail++; $display("FAIL x0_wen act=%0h exp=0", bus.rf_wen); end
    n_checks++; if (bus.rs1_busy !== 1'b1) begin n_fail++; $display("FAIL x0_busy3 act=%0h exp=1", bus.rs1_busy); end
    n_checks++; if (bus.rs2_busy !== 1'b0) begin n_fail++; $display("FAIL x0_busy0 act=%0h exp=0", bus.rs2_busy); end
    $display("x0_write: lsu rd=0 -> wen=%0h busy3=%0h busy0=%0h", bus.rf_wen, bus.rs1_busy, bus.rs2_busy);
    bus.exu_wb_valid = 1'b1; bus.exu_wb_rd = 5'd3; bus.exu_wb_data = 64'h33;
    step();
    idle_inputs();
    step();
  endtask

  task automatic test_hazard();
    logic exp_bypass_busy;
`ifdef YSYX_22040632_WB_BYPASS_EN
    exp_bypass_busy = 1'b0;
`else
    exp_bypass_busy = 1'b1;
`endif
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd7;
    #1;
    n_checks++; if (bus.iss_ready !== 1'b1) begin n_fail++; $display("FAIL hz_iss_ready_first act=%0h exp=1", bus.iss_ready); end
    step();
    n_checks++; if (bus.iss_ready !== 1'b0) begin n_fail++; $display("FAIL hz_iss_ready_waw act=%0h exp=0", bus.iss_ready); end
    bus.iss_valid = 1'b0;
    bus.rs1_addr = 5'd7; bus.rs2_addr = 5'd7;
    bus.exu_wb_valid = 1'b1; bus.exu_wb_rd = 5'd7; bus.exu_wb_data = 64'h77;
    #1;
    n_checks++; if (bus.rs1_busy !== 1'b1) begin n_fail++; $display("FAIL hz_rs1_busy_pre act=%0h exp=1", bus.rs1_busy); end
    step();
    bus.exu_wb_valid = 1'b0;
    #1;
    n_checks++; if (bus.rf_wen !== 1'b1 || bus.rf_waddr !== 5'd7) begin n_fail++; $display("FAIL hz_write act=%0h/%0h exp=1/7", bus.rf_wen, bus.rf_waddr); end
    n_checks++; if (bus.rs1_busy !== exp_bypass_busy) begin n_fail++; $display("FAIL hz_rs1_write_cycle act=%0h exp=%0h", bus.rs1_busy, exp_bypass_busy); end
    n_checks++; if (bus.rs2_busy !== exp_bypass_busy) begin n_fail++; $display("FAIL hz_rs2_write_cycle act=%0h exp=%0h", bus.rs2_busy, exp_bypass_busy); end
    step();
    n_checks++; if (bus.rs1_busy !== 1'b0) begin n_fail++; $display("FAIL hz_rs1_after act=%0h exp=0", bus.rs1_busy); end
    n_checks++; if (bus.iss_ready !== 1'b1) begin n_fail++; $display("FAIL hz_iss_ready_after act=%0h exp=1", bus.iss_ready); end
    $display("hazard: rd=7 write-cycle busy exp=%0h, after busy=%0h iss_ready=%0h", exp_bypass_busy, bus.rs1_busy, bus.iss_ready);
    idle_inputs();
  endtask

  task automatic test_set_clear_same_cycle();
    bus.exu_wb_valid = 1'b1; bus.exu_wb_rd = 5'd9; bus.exu_wb_data = 64'h99;
    step();
    bus.exu_wb_valid = 1'b0;
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd9;
    #1;
    n_checks++; if (bus.rf_wen !== 1'b1 || bus.rf_waddr !== 5'd9) begin n_fail++; $display("FAIL sc_write act=%0h/%0h exp=1/9", bus.rf_wen, bus.rf_waddr); end
    n_checks++; if (bus.iss_ready !== 1'b1) begin n_fail++; $display("FAIL sc_iss_ready act=%0h exp=1", bus.iss_ready); end
    step();
    bus.iss_valid = 1'b0;
    bus.rs1_addr = 5'd9;
    #1;
    n_checks++; if (bus.rs1_busy !== 1'b1) begin n_fail++; $display("FAIL sc_busy9 act=%0h exp=1", bus.rs1_busy); end
    $display("set_clear: issue rd=9 during write rd=9 -> busy9=%0h", bus.rs1_busy);
    bus.lsu_wb_valid = 1'b1; bus.lsu_wb_rd = 5'd9; bus.lsu_wb_data = 64'h9A;
    step();
    bus.lsu_wb_valid = 1'b0;
    step();
    n_checks++; if (bus.rs1_busy !== 1'b0) begin n_fail++; $display("FAIL sc_busy9_release act=%0h exp=0", bus.rs1_busy); end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    bus.exu_wb_valid = 1'b1; bus.exu_wb_rd = 5'd4; bus.exu_wb_data = 64'h44;
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd12;
    step();
    rst_n = 1'b0;
    bus.iss_valid = 1'b0;
    bus.exu_wb_valid = 1'b1; bus.lsu_wb_valid = 1'b1;
    bus.lsu_wb_rd = 5'd6; bus.lsu_wb_data = 64'h66;
    #1;
    n_checks++; if (bus.exu_wb_ready !== 1'b0 || bus.lsu_wb_ready !== 1'b0) begin n_fail++; $display("FAIL rm_ready_in_reset act=%0h/%0h exp=0/0", bus.exu_wb_ready, bus.lsu_wb_ready); end
    step();
    n_checks++; if (bus.rf_wen !== 1'b0) begin n_fail++; $display("FAIL rm_wen act=%0h exp=0", bus.rf_wen); end
    n_checks++; if (bus.rf_waddr !== 5'd0 || bus.rf_wdata !== 64'd0) begin n_fail++; $display("FAIL rm_port act=%0h/%0h exp=0/0", bus.rf_waddr, bus.rf_wdata); end
    bus.rs1_addr = 5'd12; bus.rs2_addr = 5'd4;
    #1;
    n_checks++; if (bus.rs1_busy !== 1'b0) begin n_fail++; $display("FAIL rm_busy12 act=%0h exp=0", bus.rs1_busy); end
    rst_n = 1'b1;
    #1;
    n_checks++; if (bus.exu_wb_ready !== 1'b1 || bus.lsu_wb_ready !== 1'b0) begin n_fail++; $display("FAIL rm_tie_grant act=%0h/%0h exp=1/0", bus.exu_wb_ready, bus.lsu_wb_ready); end
    step();
    idle_inputs();
    n_checks++; if (bus.rf_wen !== 1'b1 || bus.rf_waddr !== 5'd4) begin n_fail++; $display("FAIL rm_first_write act=%0h/%0h exp=1/4", bus.rf_wen, bus.rf_waddr); end
    $display("reset_mid: after reset tie -> waddr=%0h wen=%0h", bus.rf_waddr, bus.rf_wen);
    step();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_exu_single();
    test_back_to_back();
    test_x0_write();
    test_hazard();
    test_set_clear_same_cycle();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ysyx_22040632_rf_wb_arbiter.md
YSYX_22040632_RF_WB_ARBITER -- requirements
Module: ysyx_22040632_rf_wb_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 64, register data width.
REQ-002 SHALL have parameter NREG, default 32, architectural register count (address width log2(NREG)=5).
REQ-003 SHALL have port clk  in  1  sole clock, all state on posedge.
REQ-004 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have ports exu_wb_valid in 1 / exu_wb_ready out 1 / exu_wb_rd in 5 / exu_wb_data in XLEN: EXU writeback request.
REQ-006 SHALL have ports lsu_wb_valid in 1 / lsu_wb_ready out 1 / lsu_wb_rd in 5 / lsu_wb_data in XLEN: LSU writeback request.
REQ-007 SHALL have ports rf_wen out 1 / rf_waddr out 5 / rf_wdata out XLEN: register-file write port.
REQ-008 SHALL have ports iss_valid in 1 / iss_ready out 1 / iss_rd in 5: issue-stage destination reservation.
REQ-009 SHALL have ports rs1_addr in 5 / rs2_addr in 5 / rs1_busy out 1 / rs2_busy out 1: source hazard query.

Function
REQ-010 SHALL accept a request on a requester when valid && ready (fire); at most one fire per cycle across both requesters.
REQ-011 SHALL arbitrate round-robin: when both valid, grant the requester not granted last; single valid requester granted immediately.
REQ-012 SHALL drive ready only to the granted requester, combinationally from valids and last-grant flag; ready never depends on the requester's own data.
REQ-013 SHALL register the granted rd/data into the output stage; rf_wen/rf_waddr/rf_wdata valid exactly 1 cycle after fire; rf_wen is a one-cycle pulse per fire.
REQ-014 SHALL accept writebacks to x0 (fire occurs) but hold rf_wen=0 for them.
REQ-015 SHALL sustain one write per cycle back-to-back with no bubble.
REQ-016 SHALL keep a NREG-bit busy vector; bit set when iss_valid && iss_ready for iss_rd != 0; bit cleared in the cycle rf_wen writes that register.
REQ-017 SHALL drive iss_ready = !busy[iss_rd] (WAW stall); iss_rd = 0 always ready, never sets busy.
REQ-018 SHALL, on simultaneous set and clear of the same register, leave the bit set (new reservation wins).
REQ-019 SHALL drive rsN_busy = busy[rsN_addr]; x0 never busy.
REQ-020 SHALL update last-grant flag only on fire; flag unchanged in idle cycles.

Reset
REQ-021 SHALL, on rst_n=0 at posedge clk, clear rf_wen, rf_waddr, rf_wdata to 0, busy vector to 0, last-grant to LSU (so EXU wins first tie).
REQ-022 SHALL drop any request registered but not yet written when reset is asserted mid-operation; readies low while rst_n=0.

Configuration
REQ-023 SHALL, with YSYX_22040632_WB_BYPASS_EN defined, mask rsN_busy to 0 when rf_wen && rf_waddr == rsN_addr in the same cycle.
REQ-024 SHALL, without YSYX_22040632_WB_BYPASS_EN, report rsN_busy from the busy vector only (deasserts the cycle after the write).

Structure
REQ-025 SHALL take XLEN, REG_AW=5, NREG and a wb_req_t struct {rd, data} from shared package ysyx_22040632_pkg.
REQ-026 SHALL place the busy vector, set/clear and query logic in sub-module ysyx_22040632_scoreboard.

Verification
REQ-027 SHALL cover: EXU only, rd=5, data=0x1234 -> exu_wb_ready=1, next cycle rf_wen=1, rf_waddr=5, rf_wdata=0x1234.
REQ-028 SHALL cover: both valid 4 cycles after reset -> grants EXU, LSU, EXU, LSU; rf_wen high 4 consecutive cycles.
REQ-029 SHALL cover: LSU rd=0 data=0xFF -> lsu_wb_ready=1, rf_wen stays 0, busy unchanged.
REQ-030 SHALL cover: issue rd=7 -> busy[7]=1, iss_ready=0 for rd=7; EXU write rd=7 -> busy cleared; with bypass rs1_addr=7 busy=0 in write cycle, without it busy=1 that cycle.
REQ-031 SHALL cover: fire, then rst_n=0 next cycle -> rf_wen=0, busy all 0, next tie grants EXU.
REQ-032 SHALL cover: issue rd=9 in same cycle rf_wen writes rd=9 -> busy[9]=1 afterwards.
